mac_seq_ctrl: RTL
=================

MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clk cycles each keypad column is driven before advancing.
REQ-002 Parameter DEB_CYCLES, default 4: consecutive low samples required to accept a ns_button press.
REQ-003 Parameter WAIT_TMO, default 255: maximum cycles in WAIT before error.
REQ-004 Clocking SHALL be one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  system clock, all state on rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 ns_button  in  1  active-low next-step push button, asynchronous to clk.
REQ-008 key_row  in  4  active-low keypad row returns.
REQ-009 key_col  out  4  keypad column drive: active column 0, other columns high-impedance.
REQ-010 mac_a  out  16  operand A (half-precision) to FP MAC.
REQ-011 mac_b  out  16  operand B (half-precision) to FP MAC.
REQ-012 mac_start  out  1  one-cycle pulse launching one multiply-accumulate.
REQ-013 mac_clear  out  1  one-cycle pulse zeroing the MAC accumulator.
REQ-014 mac_done  in  1  one-cycle pulse from MAC, result valid.
REQ-015 mac_acc  in  16  MAC accumulator value.
REQ-016 disp_val  out  16  four hex digits for the seven-segment drivers.
REQ-017 status  out  5  [2:0] state code, [3] key held, [4] error flag.

Function
REQ-018 ns_button SHALL pass a 2-flop synchronizer; a press event SHALL fire once when the synchronized level has been 0 for DEB_CYCLES samples, and rearm only after it has been 1 for DEB_CYCLES samples.
REQ-019 Scanner SHALL rotate columns 0->1->2->3->0, each for SCAN_DIV cycles; rows are sampled in the last cycle of each column slot.
REQ-020 Key code SHALL be row*4+col (0x0-0xF); a key event SHALL fire once per press and rearm only after a full scan round with no row low.
REQ-021 Multiple simultaneous keys SHALL resolve to the lowest code.
REQ-022 FSM states (status[2:0]): IDLE=0, ENT_A=1, ENT_B=2, ISSUE=3, WAIT=4, SHOW=5, ERR=6.
REQ-023 IDLE --press--> ENT_A, asserting mac_clear for exactly one cycle and zeroing a_reg and b_reg.
REQ-024 In ENT_A/ENT_B a key event SHALL shift its code in: reg <= {reg[11:0], code}; the oldest digit is discarded.
REQ-025 ENT_A --press--> ENT_B; ENT_B --press--> ISSUE.
REQ-026 ISSUE SHALL last one cycle with mac_start=1, then go to WAIT.
REQ-027 WAIT --mac_done--> SHOW; after WAIT_TMO cycles without mac_done -> ERR with status[4]=1.
REQ-028 SHOW --press--> ENT_A without mac_clear, keeping the previous operands for re-edit; accumulation continues.
REQ-029 ERR --press--> IDLE, clearing status[4].
REQ-030 Key events in IDLE, ISSUE, WAIT, SHOW and ERR SHALL be ignored; press events in ISSUE and WAIT SHALL be ignored.
REQ-031 A press and a key event in the same cycle: the key is applied to the current register, then the state advances.
REQ-032 mac_a/mac_b SHALL equal a_reg/b_reg at all times.
REQ-033 disp_val SHALL be 0 in IDLE, a_reg in ENT_A, b_reg in ENT_B, mac_acc latched at mac_done in WAIT/SHOW, and 0xEEEE in ERR.
REQ-034 mac_done outside WAIT SHALL be ignored.

Reset
REQ-035 On rst: state=IDLE, a_reg=b_reg=0, disp_val=0, status=0, mac_start=mac_clear=0, scan column=0, all debounce and rearm state cleared (button considered released).
REQ-036 Reset asserted mid-WAIT SHALL abandon the operation; no mac_start is reissued after release.

Structure
REQ-037 Package mac_ctrl_pkg SHALL hold the state enum, the 16-bit operand width constant and the ERR display constant 0xEEEE.
REQ-038 Sub-module keypad_scanner SHALL contain column rotation, row sampling, priority encode and key-event rearm; the FSM, debounce and operand registers stay in mac_seq_ctrl.

Verification
REQ-039 Press; keys 3,C,0,0; press; keys 4,0,0,0; press -> one mac_clear pulse, a=0x3C00, b=0x4000, one mac_start pulse, state WAIT.
REQ-040 mac_done with mac_acc=0x4000 three cycles after mac_start -> SHOW, disp_val=0x4000; press -> ENT_A, no mac_clear.
REQ-041 Five key presses 1,2,3,4,5 in ENT_A -> a_reg=0x2345.
REQ-042 No mac_done for 255 cycles in WAIT -> ERR, status[4]=1, disp_val=0xEEEE; press -> IDLE, status=0.
REQ-043 ns_button low for 2 cycles (less than DEB_CYCLES) -> no transition; key held across 3 scan rounds -> exactly one shift.
REQ-044 rst pulse during WAIT -> all outputs at reset values; a later mac_done is ignored.

Source files
------------

// File: rtl/mac_ctrl_pkg.sv
// Shared definitions for the MAC sequencing controller.
//   OPW      : operand / display width (half-precision words)
//   ERR_DISP : display pattern shown while in the error state
//   state_e  : FSM state codes; the encoding is visible on status[2:0]
package mac_ctrl_pkg;

  localparam int OPW = 16;
  localparam logic [OPW-1:0] ERR_DISP = 16'hEEEE;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ENT_A = 3'd1,
    ST_ENT_B = 3'd2,
    ST_ISSUE = 3'd3,
    ST_WAIT  = 3'd4,
    ST_SHOW  = 3'd5,
    ST_ERR   = 3'd6
  } state_e;

endpackage

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner.
//   clk, rst   : clock, asynchronous active-high reset
//   key_row    : active-low row returns
//   key_col    : column drive, active column 0, others high-impedance
//   key_evt    : one-cycle pulse, a new key press was resolved
//   key_code   : row*4+col of the resolved key (valid with key_evt)
//   key_held   : a key was seen during the last complete scan round
// Hits are gathered over a whole round (columns 0..3) so that
// simultaneous keys in different columns resolve to the lowest code.
module keypad_scanner #(
  parameter int SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_row,
  output tri   [3:0] key_col,
  output logic       key_evt,
  output logic [3:0] key_code,
  output logic       key_held
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [DW-1:0] div_q;
  logic [1:0]    col_q;
  logic          found_q;
  logic [3:0]    best_q;
  logic          armed_q;
  logic          held_q;
  logic          evt_q;
  logic [3:0]    code_q;

  logic          slot_end;
  logic          row_hit;
  logic [1:0]    row_idx;
  logic [3:0]    cand;
  logic          found_any;
  logic [3:0]    best_any;

  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    assign key_col[gi] = (col_q == 2'(gi)) ? 1'b0 : 1'bz;
  end

  assign slot_end = (div_q == DW'(SCAN_DIV - 1));

  // Lowest low row in the active column wins.
  always_comb begin
    row_hit = 1'b0;
    row_idx = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (!key_row[r]) begin
        row_hit = 1'b1;
        row_idx = 2'(r);
      end
    end
  end

  assign cand      = {row_idx, col_q};
  assign found_any = found_q | row_hit;
  assign best_any  = (row_hit && (!found_q || cand < best_q)) ? cand : best_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q   <= '0;
      col_q   <= 2'd0;
      found_q <= 1'b0;
      best_q  <= 4'd0;
      armed_q <= 1'b1;
      held_q  <= 1'b0;
      evt_q   <= 1'b0;
      code_q  <= 4'd0;
    end else begin
      evt_q <= 1'b0;
      if (slot_end) begin
        div_q <= '0;
        col_q <= col_q + 2'd1;
        if (col_q == 2'd3) begin
          // End of round: fire once per press, rearm only after a clean round.
          found_q <= 1'b0;
          held_q  <= found_any;
          if (found_any) begin
            if (armed_q) begin
              evt_q  <= 1'b1;
              code_q <= best_any;
            end
            armed_q <= 1'b0;
          end else begin
            armed_q <= 1'b1;
          end
        end else begin
          found_q <= found_any;
          best_q  <= best_any;
        end
      end else begin
        div_q <= div_q + DW'(1);
      end
    end
  end

  assign key_evt  = evt_q;
  assign key_code = code_q;
  assign key_held = held_q;

endmodule

// File: rtl/mac_seq_ctrl.sv
// Operator front end for a half-precision multiply-accumulate unit.
//   clk, rst          : clock, asynchronous active-high reset
//   ns_button         : active-low next-step button (asynchronous)
//   key_row / key_col : keypad matrix (rows in, columns out)
//   mac_a, mac_b      : operands to the MAC
//   mac_start         : one-cycle launch pulse
//   mac_clear         : one-cycle accumulator clear pulse
//   mac_done, mac_acc : MAC completion pulse and accumulator value
//   disp_val          : four hex digits for the display
//   status            : {error, key held, state code}
module mac_seq_ctrl
  import mac_ctrl_pkg::*;
#(
  parameter int SCAN_DIV   = 1000,
  parameter int DEB_CYCLES = 4,
  parameter int WAIT_TMO   = 255
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ns_button,
  input  logic [3:0]     key_row,
  output tri   [3:0]     key_col,
  output logic [OPW-1:0] mac_a,
  output logic [OPW-1:0] mac_b,
  output logic           mac_start,
  output logic           mac_clear,
  input  logic           mac_done,
  input  logic [OPW-1:0] mac_acc,
  output logic [OPW-1:0] disp_val,
  output logic [4:0]     status
);

  localparam int DCW = $clog2(DEB_CYCLES + 1);
  localparam int TW  = $clog2(WAIT_TMO + 1);

  logic           key_evt;
  logic [3:0]     key_code;
  logic           key_held;

  logic           btn_s1_q, btn_s2_q;
  logic           deb_lvl_q;
  logic [DCW-1:0] deb_cnt_q;
  logic           press;

  state_e         state_q, state_d;
  logic [OPW-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           clear_q, clear_d;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .clk      (clk),
    .rst      (rst),
    .key_row  (key_row),
    .key_col  (key_col),
    .key_evt  (key_evt),
    .key_code (key_code),
    .key_held (key_held)
  );

  // deb_lvl_q is the accepted button level (1 = released); it flips after
  // DEB_CYCLES consecutive opposite samples, and only the 1->0 flip is a press.
  assign press = (btn_s2_q != deb_lvl_q) && deb_lvl_q &&
                 (deb_cnt_q == DCW'(DEB_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s1_q  <= 1'b1;
      btn_s2_q  <= 1'b1;
      deb_lvl_q <= 1'b1;
      deb_cnt_q <= '0;
    end else begin
      btn_s1_q <= ns_button;
      btn_s2_q <= btn_s1_q;
      if (btn_s2_q == deb_lvl_q) begin
        deb_cnt_q <= '0;
      end else if (deb_cnt_q == DCW'(DEB_CYCLES - 1)) begin
        deb_lvl_q <= btn_s2_q;
        deb_cnt_q <= '0;
      end else begin
        deb_cnt_q <= deb_cnt_q + DCW'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    tmo_d   = tmo_q;
    clear_d = 1'b0;
    case (state_q)
      ST_IDLE: if (press) begin
        state_d = ST_ENT_A;
        clear_d = 1'b1;
        a_d     = '0;
        b_d     = '0;
      end
      // Key is applied before the press moves the state on.
      ST_ENT_A: begin
        if (key_evt) a_d = {a_q[11:0], key_code};
        if (press)   state_d = ST_ENT_B;
      end
      ST_ENT_B: begin
        if (key_evt) b_d = {b_q[11:0], key_code};
        if (press)   state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        tmo_d   = '0;
      end
      ST_WAIT: begin
        if (mac_done) begin
          acc_d   = mac_acc;
          state_d = ST_SHOW;
        end else if (tmo_q == TW'(WAIT_TMO - 1)) begin
          state_d = ST_ERR;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_SHOW: if (press) state_d = ST_ENT_A;
      ST_ERR:  if (press) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      tmo_q   <= '0;
      clear_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      tmo_q   <= tmo_d;
      clear_q <= clear_d;
    end
  end

  always_comb begin
    case (state_q)
      ST_IDLE:  disp_val = '0;
      ST_ENT_A: disp_val = a_q;
      ST_ENT_B: disp_val = b_q;
      ST_ERR:   disp_val = ERR_DISP;
      default:  disp_val = acc_q;
    endcase
  end

  assign mac_a     = a_q;
  assign mac_b     = b_q;
  assign mac_start = (state_q == ST_ISSUE);
  assign mac_clear = clear_q;
  assign status    = {state_q == ST_ERR, key_held, state_q};

endmodule
